// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter: icache (read-only) and dcache share one bus port.
// Define ARB_RR_EN for round-robin priority; default build uses fixed dcache priority.
module mem_bus_arbiter #(
   parameter int A_WIDTH = 32
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic [A_WIDTH-1:0] i_a,
   input  logic               i_strobe,
   output logic [31:0]        i_rdata,
   output logic               i_ready,
   input  logic [A_WIDTH-1:0] d_a,
   input  logic [31:0]        d_wdata,
   input  logic               d_strobe,
   input  logic               d_rw,
   input  logic [1:0]         d_size,
   output logic [31:0]        d_rdata,
   output logic               d_ready,
   output logic [A_WIDTH-1:0] m_a,
   output logic [31:0]        m_din,
   input  logic [31:0]        m_dout,
   output logic               m_strobe,
   output logic               m_rw,
   output logic [1:0]         m_size,
   input  logic               m_ready,
   output logic [1:0]         grant
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   state_t state, state_nxt;
   logic   pick_d;

`ifdef ARB_RR_EN
   logic ptr_d;

   // Pointer set means the dcache wins a tie; flips on every completed transaction.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         ptr_d <= 1'b1;
      else if (state != IDLE && m_ready)
         ptr_d <= ~ptr_d;
   end

   always_comb begin
      pick_d = d_strobe & (~i_strobe | ptr_d);
   end
`else
   always_comb begin
      pick_d = d_strobe;
   end
`endif

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (pick_d)
               state_nxt = D_BUSY;
            else if (i_strobe)
               state_nxt = I_BUSY;
         end
         I_BUSY, D_BUSY: begin
            if (m_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant   = 2'b00;
      i_ready = 1'b0;
      d_ready = 1'b0;
      case (state)
         I_BUSY: begin
            grant   = 2'b01;
            i_ready = m_ready;
         end
         D_BUSY: begin
            grant   = 2'b10;
            d_ready = m_ready;
         end
         default: grant = 2'b00;
      endcase
   end

   assign i_rdata = m_dout;
   assign d_rdata = m_dout;

   // Bus request registers: loaded only in IDLE, frozen while a transaction is outstanding.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         m_a      <= '0;
         m_din    <= '0;
         m_strobe <= 1'b0;
         m_rw     <= 1'b0;
         m_size   <= 2'b10;
      end else if (state == IDLE) begin
         if (pick_d) begin
            m_a      <= d_a;
            m_din    <= d_wdata;
            m_rw     <= d_rw;
            m_size   <= d_size;
            m_strobe <= 1'b1;
         end else if (i_strobe) begin
            m_a      <= i_a;
            m_rw     <= 1'b0;
            m_size   <= 2'b10;
            m_strobe <= 1'b1;
         end
      end else if (m_ready) begin
         m_strobe <= 1'b0;
         m_rw     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; inputs driven and outputs
// sampled 2 time units after each rising edge.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        clrn;
   logic [31:0] i_a;
   logic        i_strobe;
   logic [31:0] i_rdata;
   logic        i_ready;
   logic [31:0] d_a;
   logic [31:0] d_wdata;
   logic        d_strobe;
   logic        d_rw;
   logic [1:0]  d_size;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic [31:0] m_a;
   logic [31:0] m_din;
   logic [31:0] m_dout;
   logic        m_strobe;
   logic        m_rw;
   logic [1:0]  m_size;
   logic        m_ready;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(.A_WIDTH(32)) dut (
      .clk(clk), .clrn(clrn),
      .i_a(i_a), .i_strobe(i_strobe), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_a(d_a), .d_wdata(d_wdata), .d_strobe(d_strobe), .d_rw(d_rw),
      .d_size(d_size), .d_rdata(d_rdata), .d_ready(d_ready),
      .m_a(m_a), .m_din(m_din), .m_dout(m_dout), .m_strobe(m_strobe),
      .m_rw(m_rw), .m_size(m_size), .m_ready(m_ready), .grant(grant)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      clrn = 1'b0; i_a = '0; i_strobe = 1'b0; d_a = '0; d_wdata = '0;
      d_strobe = 1'b0; d_rw = 1'b0; d_size = 2'b00; m_dout = '0; m_ready = 1'b0;
      #12;
      checks++;
      if ({m_strobe, m_rw, m_size, grant, i_ready, d_ready} !== 8'b0_0_10_00_0_0) begin
         errors++;
         $display("FAIL reset_ctrl: got strobe=%b rw=%b size=%b grant=%b ir=%b dr=%b required 0 0 10 00 0 0",
                  m_strobe, m_rw, m_size, grant, i_ready, d_ready);
      end
      checks++;
      if (m_a !== 32'h0 || m_din !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got m_a=%h m_din=%h required 0 0", m_a, m_din);
      end
      @(posedge clk); #2;
      clrn = 1'b1;
      tick;
   endtask

   task automatic test_icache_read;
      i_a = 32'h1FC00000; i_strobe = 1'b1;
      tick;
      checks++;
      if (grant !== 2'b01 || m_strobe !== 1'b1 || m_a !== 32'h1FC00000 || m_rw !== 1'b0 || m_size !== 2'b10) begin
         errors++;
         $display("FAIL ird_req: got grant=%b strobe=%b m_a=%h rw=%b size=%b required 01 1 1fc00000 0 10",
                  grant, m_strobe, m_a, m_rw, m_size);
      end
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++;
         if (i_ready !== 1'b0 || grant !== 2'b01 || m_strobe !== 1'b1) begin
            errors++;
            $display("FAIL ird_wait%0d: got ready=%b grant=%b strobe=%b required 0 01 1", k, i_ready, grant, m_strobe);
         end
      end
      m_ready = 1'b1; m_dout = 32'h3C1DBFC0;
      #1;
      checks++;
      if (i_ready !== 1'b1 || i_rdata !== 32'h3C1DBFC0 || d_ready !== 1'b0) begin
         errors++;
         $display("FAIL ird_ack: got i_ready=%b i_rdata=%h d_ready=%b required 1 3c1dbfc0 0", i_ready, i_rdata, d_ready);
      end
      tick;
      m_ready = 1'b0; i_strobe = 1'b0;
      #1;
      checks++;
      if (i_ready !== 1'b0 || grant !== 2'b00 || m_strobe !== 1'b0) begin
         errors++;
         $display("FAIL ird_done: got ready=%b grant=%b strobe=%b required 0 00 0", i_ready, grant, m_strobe);
      end
      tick;
   endtask

   task automatic test_dcache_write;
      d_a = 32'h80000013; d_wdata = 32'h000000AB; d_rw = 1'b1; d_size = 2'b00; d_strobe = 1'b1;
      tick;
      checks++;
      if (grant !== 2'b10 || m_strobe !== 1'b1 || m_rw !== 1'b1 || m_size !== 2'b00 ||
          m_din !== 32'h000000AB || m_a !== 32'h80000013) begin
         errors++;
         $display("FAIL dwr_req: got grant=%b strobe=%b rw=%b size=%b din=%h a=%h required 10 1 1 00 000000ab 80000013",
                  grant, m_strobe, m_rw, m_size, m_din, m_a);
      end
      d_wdata = 32'hFFFFFFFF; d_a = 32'h00000040; d_size = 2'b10;
      tick;
      tick;
      checks++;
      if (m_din !== 32'h000000AB || m_a !== 32'h80000013 || m_size !== 2'b00 || d_ready !== 1'b0) begin
         errors++;
         $display("FAIL dwr_hold: got din=%h a=%h size=%b ready=%b required 000000ab 80000013 00 0",
                  m_din, m_a, m_size, d_ready);
      end
      m_ready = 1'b1;
      #1;
      checks++;
      if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
         errors++;
         $display("FAIL dwr_ack: got d_ready=%b i_ready=%b required 1 0", d_ready, i_ready);
      end
      tick;
      m_ready = 1'b0; d_strobe = 1'b0; d_rw = 1'b0;
      #1;
      checks++;
      if (d_ready !== 1'b0 || grant !== 2'b00 || m_strobe !== 1'b0 || m_rw !== 1'b0) begin
         errors++;
         $display("FAIL dwr_done: got ready=%b grant=%b strobe=%b rw=%b required 0 00 0 0", d_ready, grant, m_strobe, m_rw);
      end
      tick;
   endtask

   task automatic test_simultaneous;
      logic [1:0] exp_g [4];
      exp_g[0] = 2'b10; exp_g[1] = 2'b01; exp_g[2] = 2'b10; exp_g[3] = 2'b01;
      clrn = 1'b0;
      #3;
      clrn = 1'b1;
      tick;
      i_a = 32'h00001000; d_a = 32'h00002000; d_rw = 1'b0; d_size = 2'b10;
      i_strobe = 1'b1; d_strobe = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick;
         checks++;
         if (grant !== exp_g[k] || m_strobe !== 1'b1) begin
            errors++;
            $display("FAIL sim_grant%0d: got grant=%b strobe=%b required %b 1", k, grant, m_strobe, exp_g[k]);
         end
         checks++;
         if (m_a !== ((exp_g[k] == 2'b10) ? 32'h00002000 : 32'h00001000)) begin
            errors++;
            $display("FAIL sim_addr%0d: got m_a=%h for grant %b", k, m_a, exp_g[k]);
         end
         m_ready = 1'b1;
         tick;
         m_ready = 1'b0;
         checks++;
         if (grant !== 2'b00) begin
            errors++;
            $display("FAIL sim_idle%0d: got grant=%b required 00", k, grant);
         end
`ifndef ARB_RR_EN
         // Fixed priority: dcache re-requests while icache is still pending and wins again.
         if (k == 0) d_strobe = 1'b0;
         if (k == 1) d_strobe = 1'b1;
         if (k == 2) d_strobe = 1'b0;
`endif
      end
      i_strobe = 1'b0; d_strobe = 1'b0;
      tick;
   endtask

   task automatic test_stray_ready;
      m_ready = 1'b1;
      #1;
      checks++;
      if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
         errors++;
         $display("FAIL stray_pulse: got i_ready=%b d_ready=%b required 0 0", i_ready, d_ready);
      end
      tick;
      checks++;
      if (grant !== 2'b00 || m_strobe !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
         errors++;
         $display("FAIL stray_state: got grant=%b strobe=%b ir=%b dr=%b required 00 0 0 0", grant, m_strobe, i_ready, d_ready);
      end
      i_a = 32'h00000300; i_strobe = 1'b1;
      tick;
      checks++;
      if (grant !== 2'b01 || m_strobe !== 1'b1 || i_ready !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_ack: got grant=%b strobe=%b i_ready=%b required 01 1 1", grant, m_strobe, i_ready);
      end
      tick;
      m_ready = 1'b0; i_strobe = 1'b0;
      checks++;
      if (grant !== 2'b00 || m_strobe !== 1'b0) begin
         errors++;
         $display("FAIL same_cycle_done: got grant=%b strobe=%b required 00 0", grant, m_strobe);
      end
      tick;
   endtask

   task automatic test_reset_mid;
      d_a = 32'h00000500; d_wdata = 32'h12345678; d_rw = 1'b1; d_size = 2'b10; d_strobe = 1'b1;
      tick;
      checks++;
      if (grant !== 2'b10 || m_strobe !== 1'b1) begin
         errors++;
         $display("FAIL rmid_busy: got grant=%b strobe=%b required 10 1", grant, m_strobe);
      end
      #1;
      clrn = 1'b0;
      #1;
      checks++;
      if (m_strobe !== 1'b0 || grant !== 2'b00 || m_rw !== 1'b0 || m_a !== 32'h0) begin
         errors++;
         $display("FAIL rmid_abort: got strobe=%b grant=%b rw=%b a=%h required 0 00 0 0", m_strobe, grant, m_rw, m_a);
      end
      d_strobe = 1'b0; d_rw = 1'b0;
      tick;
      clrn = 1'b1;
      i_a = 32'h00000700; i_strobe = 1'b1;
      tick;
      checks++;
      if (grant !== 2'b01 || m_strobe !== 1'b1 || m_a !== 32'h00000700) begin
         errors++;
         $display("FAIL rmid_regrant: got grant=%b strobe=%b a=%h required 01 1 00000700", grant, m_strobe, m_a);
      end
      m_ready = 1'b1; m_dout = 32'hCAFEF00D;
      #1;
      checks++;
      if (i_ready !== 1'b1 || i_rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL rmid_ack: got i_ready=%b i_rdata=%h required 1 cafef00d", i_ready, i_rdata);
      end
      tick;
      m_ready = 1'b0; i_strobe = 1'b0;
      tick;
   endtask

   initial begin
      test_reset;
      test_icache_read;
      test_dcache_write;
      test_simultaneous;
      test_stray_ready;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single memory port shared by the instruction cache (read-only) and the write-through data cache.
- Sits between both cache miss/write ports and the memory/bus bridge.
- Grants one transaction at a time, registers its address, data, size and direction, holds them stable until memory acknowledges, then returns data and ready to the owner.

Parameters:
A_WIDTH, 32, address width of all ports

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
i_a  in  A_WIDTH  icache request address
i_strobe  in  1  icache read request; held high until i_ready
i_rdata  out  32  read data to icache
i_ready  out  1  icache transaction complete
d_a  in  A_WIDTH  dcache request address
d_wdata  in  32  dcache write data
d_strobe  in  1  dcache request; held high until d_ready
d_rw  in  1  0 read, 1 write
d_size  in  2  00 byte, 01 half, 10 word
d_rdata  out  32  read data to dcache
d_ready  out  1  dcache transaction complete
m_a  out  A_WIDTH  memory address (registered)
m_din  out  32  memory write data (registered)
m_dout  in  32  memory read data
m_strobe  out  1  memory request (registered)
m_rw  out  1  memory direction (registered)
m_size  out  2  memory access size (registered)
m_ready  in  1  memory acknowledge, one cycle
grant  out  2  current owner: 00 none, 01 icache, 10 dcache

Behaviour:
- Clock and reset: single clock clk; clrn asynchronous, active-low.
- Reset values:
  - State IDLE.
  - m_strobe=0, m_rw=0, m_size=2'b10, m_a=0, m_din=0.
  - grant=00, i_ready=0, d_ready=0.
  - Priority pointer points to dcache.
- States: IDLE, I_BUSY, D_BUSY.
- IDLE, at posedge:
  - If d_strobe is sampled high (priority winner), go to D_BUSY. Latch m_a=d_a, m_din=d_wdata, m_rw=d_rw, m_size=d_size, m_strobe=1.
  - Else if i_strobe, go to I_BUSY. Latch m_a=i_a, m_rw=0, m_size=10, m_strobe=1.
  - Else stay in IDLE.
- I_BUSY/D_BUSY:
  - Outputs hold constant while m_ready=0; no timeout.
  - On a posedge with m_ready=1: go to IDLE, m_strobe=0, m_rw=0.
- Ready signals (combinational):
  - i_ready = (state==I_BUSY) & m_ready.
  - d_ready = (state==D_BUSY) & m_ready.
  - Each is a single-cycle pulse.
- Read data: i_rdata=m_dout and d_rdata=m_dout (combinational passthrough). Valid only while the matching ready is high.
- grant reflects state: 01 in I_BUSY, 10 in D_BUSY, else 00.
- Latency: request sampled at edge N; m_strobe high from cycle N+1; ready in the first cycle m_ready=1. Minimum 2 cycles from strobe to ready.
- Back-to-back: one mandatory IDLE cycle between transactions, so requesters have one cycle to drop strobe.
- Simultaneous requests: dcache wins (fixed priority). The icache request stays pending and is granted on the next IDLE if still asserted.
- Requester drops strobe mid-transaction: the transaction still completes on memory; the ready pulse is still generated and may be ignored.
- Stray m_ready:
  - m_ready in IDLE is ignored; no ready pulse, no state change.
  - m_ready asserted in the same cycle m_strobe first rises is a valid acknowledge.
- Inputs are not sampled outside IDLE. Changes to address or data during BUSY have no effect.
- Reset mid-transaction aborts immediately to reset values; the memory side must tolerate m_strobe dropping.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin priority.
  - A 1-bit pointer flips to the other requester on every completed transaction (m_ready in BUSY).
  - On simultaneous requests in IDLE, the requester named by the pointer wins.
  - Pointer reset value = dcache.
- Undefined: fixed dcache priority as above. The pointer logic is not synthesized.

Test Plan:
- Single icache read: i_strobe=1, i_a=0x1FC00000; memory acks 3 cycles after m_strobe with m_dout=0x3C1DBFC0 -> m_a=0x1FC00000, m_rw=0, m_size=10; i_ready pulses once with i_rdata=0x3C1DBFC0; grant 01 then 00.
- Dcache byte write: d_strobe=1, d_rw=1, d_size=00, d_a=0x80000013, d_wdata=0xAB -> m_rw=1, m_size=00, m_din=0xAB held stable until m_ready; d_ready single pulse; icache idle.
- Simultaneous i_strobe and d_strobe held:
  - Without ARB_RR_EN: order D, I, D, I ... only as each releases. Dcache always served first; the icache is served after the dcache releases, with one IDLE cycle between.
  - With ARB_RR_EN and both held continuously: grants alternate D, I, D, I.
- Stray m_ready=1 in IDLE -> no i_ready/d_ready pulse; state stays IDLE.
- Reset mid-transaction: clrn low during D_BUSY before m_ready -> m_strobe=0, grant=00 asynchronously; after release, a new i_strobe is granted normally.
